// File: rtl/mult_booth_seq.sv
// Iterative radix-4 Booth multiplier for MUL/MULH/MULHSU/MULHU, two multiplier bits per clock.
// Latency: accepted in cycle T, done_o pulses in cycle T+ITER+1 (T+18 for XLEN=32).
// Backpressure: start_i is ignored while busy_o is high; kill_i aborts in flight without a done_o.
module mult_booth_seq #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start_i,
   input  logic [1:0]      op_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   input  logic            kill_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);

   localparam int ITER = (XLEN + 2) / 2;
   localparam int CW   = $clog2(ITER + 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t            state, state_nxt;
   logic              accept;
   logic              last_iter;

   logic [XLEN+1:0]   a_q;       // extended multiplicand
   logic [XLEN+1:0]   b_q;       // extended multiplier, becomes product low bits
   logic              q_q;       // Booth history bit
   logic [XLEN+3:0]   acc_q;     // signed accumulator (upper product bits)
   logic [CW-1:0]     cnt_q;
   logic              hi_sel_q;
   logic [XLEN-1:0]   result_q;

   logic [XLEN+3:0]   a_ext;
   logic [XLEN+3:0]   addend;
   logic [XLEN+3:0]   sum;
   logic [XLEN+3:0]   acc_nxt;
   logic [XLEN+1:0]   b_nxt;
   logic              q_nxt;
   logic [2*XLEN-1:0] product;
   logic              sign_a;
   logic              sign_b;

   assign last_iter = (cnt_q == CW'(ITER - 1));
   assign result_o  = result_q;

   // MULHU treats rs1 as unsigned; MULHSU and MULHU treat rs2 as unsigned.
   assign sign_a = (op_i != 2'b11) & rs1_i[XLEN-1];
   assign sign_b = ~op_i[1] & rs2_i[XLEN-1];

   // One Booth step: select digit*A, accumulate, then arithmetic shift {acc,B,q} right by 2.
   always_comb begin
      a_ext = {{2{a_q[XLEN+1]}}, a_q};
      unique case ({b_q[1:0], q_q})
         3'b001, 3'b010: addend = a_ext;
         3'b011:         addend = a_ext << 1;
         3'b100:         addend = -(a_ext << 1);
         3'b101, 3'b110: addend = -a_ext;
         default:        addend = '0;
      endcase
      sum     = acc_q + addend;
      acc_nxt = {{2{sum[XLEN+3]}}, sum[XLEN+3:2]};
      b_nxt   = {sum[1:0], b_q[XLEN+1:2]};
      q_nxt   = b_q[1];
      // After ITER shifts B holds the low XLEN+2 product bits, acc the rest.
      product = {acc_nxt[XLEN-3:0], b_nxt};
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic and handshake outputs; kill beats start in IDLE.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      busy_o    = (state != IDLE);
      done_o    = (state == DONE);
      unique case (state)
         IDLE: begin
            if (start_i && !kill_i) begin
               accept    = 1'b1;
               state_nxt = CALC;
            end
         end
         CALC: begin
            if (kill_i)         state_nxt = IDLE;
            else if (last_iter) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: load operands on accept, iterate in CALC, capture result on the last step.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q      <= '0;
         b_q      <= '0;
         q_q      <= 1'b0;
         acc_q    <= '0;
         cnt_q    <= '0;
         hi_sel_q <= 1'b0;
         result_q <= '0;
      end else if (accept) begin
         a_q      <= {{2{sign_a}}, rs1_i};
         b_q      <= {{2{sign_b}}, rs2_i};
         q_q      <= 1'b0;
         acc_q    <= '0;
         cnt_q    <= '0;
         hi_sel_q <= (op_i != 2'b00);
      end else if (state == CALC && !kill_i) begin
         acc_q <= acc_nxt;
         b_q   <= b_nxt;
         q_q   <= q_nxt;
         cnt_q <= cnt_q + 1'b1;
         if (last_iter)
            result_q <= hi_sel_q ? product[2*XLEN-1:XLEN] : product[XLEN-1:0];
      end
   end

endmodule

// File: doc/mult_booth_seq.md
Name: mult_booth_seq

Overview:
- Iterative radix-4 Booth multiplier for the RV32IM execute stage, parametrised in operand width.
- Supports all four RISC-V M-extension multiply ops: MUL, MULH, MULHSU, MULHU.
- Uses a start/busy/done handshake with pipeline-flush abort. Retires 2 multiplier bits per clock instead of a single combinational partial-product tree.
- Sits beside the divider in the MULT-DIV unit. The core stalls on busy_o.

Parameters:
- XLEN, 32, operand and result width. Must be even and at least 4.
- ITER (localparam), (XLEN+2)/2, number of Booth iterations. Equals 17 for XLEN=32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start_i  input  1  request a new multiply; sampled only in IDLE
- op_i  input  2  operation: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
- rs1_i  input  XLEN  multiplicand
- rs2_i  input  XLEN  multiplier
- kill_i  input  1  abort the operation in flight (pipeline flush)
- busy_o  output  1  high while an operation is accepted and not finished
- done_o  output  1  one-cycle pulse; result_o is valid in this cycle
- result_o  output  XLEN  product, lower or upper half as selected by op_i

Behaviour:
- Reset (async, rst=1): state=IDLE; busy_o=0, done_o=0, result_o=0; all internal registers zero. Reset mid-operation discards the operation and produces no done_o.
- States: IDLE, CALC, DONE.
- IDLE -> CALC when start_i=1 and kill_i=0 (acceptance cycle T). In cycle T, latch the following:
  - A = rs1_i extended to XLEN+2 bits: sign-extend for MUL/MULH/MULHSU, zero-extend for MULHU.
  - B = rs2_i extended to XLEN+2 bits: sign-extend for MUL/MULH, zero-extend for MULHSU/MULHU.
  - hi_sel = (op_i != 00).
  - Accumulator = 0, Booth history bit q = 0, counter = 0.
- CALC, one iteration per cycle:
  - Booth digit from {B[1],B[0],q}: 000/111 -> 0; 001/010 -> +A; 011 -> +2A; 100 -> -2A; 101/110 -> -A.
  - Add digit*A into the upper (XLEN+4)-bit signed accumulator.
  - Arithmetic-shift the combined {acc,B,q} right by 2.
  - Increment counter. After ITER iterations (counter=ITER-1), go to DONE.
- DONE:
  - done_o=1 for exactly this cycle; result_o updated this cycle.
  - The 2*XLEN product is the low 2*XLEN bits of the final signed product. result_o = product[XLEN-1:0] if hi_sel=0, else product[2*XLEN-1:XLEN].
  - Next state is IDLE.
- Latency: accepted in cycle T -> done_o in cycle T+ITER+1 (T+18 for XLEN=32). The next start_i can be accepted in cycle T+ITER+2.
- busy_o = 1 in CALC and DONE, 0 in IDLE. This is registered and deasserts the cycle after done_o.
- result_o holds its value between done_o pulses. It is unchanged by kill_i and by ignored starts.
- start_i while busy_o=1 is ignored; the inputs are not sampled.
- Operand inputs are sampled only in cycle T. Changes afterwards have no effect.
- kill_i=1 in CALC or DONE:
  - Next state is IDLE, busy_o=0 next cycle.
  - If kill_i arrives in DONE, done_o is still 1 in that cycle, because it is already asserted.
  - In CALC, no done_o is ever produced for the killed operation.
- kill_i=1 and start_i=1 together in IDLE: kill wins and the start is not accepted.
- Arithmetic uses wrap-around modulo 2^(XLEN+4) inside the accumulator. There is no overflow flag; edge operands (most-negative x most-negative) must still yield the exact product.

Test Plan:
- MUL: rs1=7, rs2=0xFFFFFFFD (-3), op=00 -> done_o exactly 18 cycles after acceptance, result_o=0xFFFFFFEB; busy_o high for 18 cycles.
- MULH most-negative squared: rs1=rs2=0x80000000, op=01 -> result_o=0x40000000. The same operands with op=00 give 0x00000000.
- MULHU/MULHSU: rs1=rs2=0xFFFFFFFF, op=11 -> 0xFFFFFFFE; op=10 -> 0xFFFFFFFF; op=01 -> 0x00000000.
- Handshake: pulse start_i again at cycles T+5 and T+18 with different operands -> both ignored, only one done_o. A start at T+19 is accepted and completes at T+37.
- Kill: start MUL 3*5, assert kill_i at T+6 -> no done_o, busy_o=0 at T+7, result_o keeps its previous value. A start and kill together in IDLE -> not accepted.
- Async reset: assert rst at T+9 between clock edges -> busy_o, done_o and result_o go to 0 immediately. After release, a fresh MUL 0x0000FFFF*0x0000FFFF -> result_o=0xFFFE0001.
